// File: rtl/regfile_access_ctrl.sv
// Request queue and sequencer in front of a single-address-port register file.
// Buffers read/write requests in order, issues one per cycle, and holds read responses.
module regfile_access_ctrl #(
  parameter int n          = 8,
  parameter int addr_width = 5,
  parameter int regcount   = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [n-1:0]          req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [n-1:0]          rsp_data,
  output logic                  rsp_err,
  output logic                  wr_err,
  output logic                  busy,
  output logic                  WE,
  output logic [addr_width-1:0] Rs1,
  output logic [n-1:0]          Data,
  input  logic [n-1:0]          Rd1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // One extra bit so regcount == 2**addr_width still compares correctly.
  localparam logic [addr_width:0] REGCOUNT_C = (addr_width + 1)'(regcount);

  logic                  fifo_write_r [DEPTH];
  logic [addr_width-1:0] fifo_addr_r  [DEPTH];
  logic [n-1:0]          fifo_wdata_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic                  rsp_valid_r;
  logic [n-1:0]          rsp_data_r;
  logic                  rsp_err_r;
  logic                  wr_err_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  issue_s;
  logic                  head_write_s;
  logic [addr_width-1:0] head_addr_s;
  logic [n-1:0]          head_wdata_s;
  logic                  in_range_s;

  // Head decode and issue decision.
  always_comb begin
    empty_s      = (count_r == CW'(0));
    full_s       = (count_r == CW'(DEPTH));
    head_write_s = fifo_write_r[rd_ptr_r];
    head_addr_s  = fifo_addr_r[rd_ptr_r];
    head_wdata_s = fifo_wdata_r[rd_ptr_r];
    in_range_s   = ({1'b0, head_addr_s} < REGCOUNT_C);
    // A held, unconsumed response blocks only reads; writes never stall.
    issue_s      = !empty_s && (head_write_s || !rsp_valid_r || rsp_ready);
    push_s       = req_valid && !full_s;
    pop_s        = issue_s;
  end

  assign req_ready = !full_s;
  assign WE        = issue_s & head_write_s & in_range_s & nReset;
  assign Rs1       = empty_s ? {addr_width{1'b0}} : head_addr_s;
  assign Data      = head_wdata_s;
  assign busy      = !empty_s | rsp_valid_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign wr_err    = wr_err_r;

  // Request FIFO storage, pointers and occupancy count.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_write_r[i] <= 1'b0;
        fifo_addr_r[i]  <= {addr_width{1'b0}};
        fifo_wdata_r[i] <= {n{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_write_r[wr_ptr_r] <= req_write;
        fifo_addr_r[wr_ptr_r]  <= req_addr;
        fifo_wdata_r[wr_ptr_r] <= req_wdata;
        wr_ptr_r               <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Read response holding register and dropped-write error pulse.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {n{1'b0}};
      rsp_err_r   <= 1'b0;
      wr_err_r    <= 1'b0;
    end else begin
      wr_err_r <= issue_s & head_write_s & !in_range_s;
      if (issue_s && !head_write_s) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= in_range_s ? Rd1 : {n{1'b0}};
        rsp_err_r   <= !in_range_s;
      end else if (rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file.
// Stimulus queues expected responses/writes; a negedge monitor pops and compares.
module tb_regfile_access_ctrl;

  localparam int RC = 10;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       req_valid, req_ready, req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, wr_err, busy, WE;
  logic [7:0] rsp_data, Data, Rd1;
  logic [4:0] Rs1;

  int total = 0;
  int bad   = 0;

  logic [7:0] regs [0:RC-1];

  typedef struct packed {logic [7:0] data; logic err;} rsp_t;
  typedef struct packed {logic [4:0] addr; logic [7:0] data;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  regfile_access_ctrl #(.n(8), .addr_width(5), .regcount(RC), .DEPTH(4)) dut (
    .Clock(Clock), .nReset(nReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .wr_err(wr_err), .busy(busy),
    .WE(WE), .Rs1(Rs1), .Data(Data), .Rd1(Rd1)
  );

  always #5 Clock = ~Clock;

  // Register file model: combinational read, write on posedge.
  assign Rd1 = (Rs1 < 5'(RC)) ? regs[Rs1[3:0]] : 8'h00;
  always @(posedge Clock) begin
    if (WE === 1'b1 && Rs1 < 5'(RC)) regs[Rs1[3:0]] <= Data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare consumed responses and issued writes against the queues.
  always @(negedge Clock) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got data=%0h err=%0b want none", rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (WE === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_we: got Rs1=%0h Data=%0h want none", Rs1, Data);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("we_addr", 32'(Rs1), 32'(w.addr));
        chk("we_data", 32'(Data), 32'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d,
                      input logic [7:0] ed, input logic ee);
    int waited;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: got req_ready=%0b want 1", req_ready);
    end else if (!w) begin
      rsp_q.push_back('{data: ed, err: ee});
    end else if (a < 5'(RC)) begin
      wr_q.push_back('{addr: a, data: d});
    end
    tick();
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < RC; i++) regs[i] = 8'h10 + 8'(i);
    nReset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 5'd0; req_wdata = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    nReset = 1'b1;

    // Reset then idle.
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_wr_err", 32'(wr_err), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_we", 32'(WE), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h1);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // Write r3 then read it back; check issue and response latency.
    rsp_ready = 1'b1;
    send(1'b1, 5'd3, 8'hA5, 8'h00, 1'b0);
    chk("wr_we", 32'(WE), 32'h1);
    chk("wr_rs1", 32'(Rs1), 32'h3);
    chk("wr_data", 32'(Data), 32'hA5);
    send(1'b0, 5'd3, 8'h00, 8'hA5, 1'b0);
    chk("rd_lat_early", 32'(rsp_valid), 32'h0);
    req_valid = 1'b0;
    tick();
    chk("rd_lat_valid", 32'(rsp_valid), 32'h1);
    chk("rd_lat_data", 32'(rsp_data), 32'hA5);
    idle(3);

    // Back-to-back writes never fill the queue.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 5'(4 + i), 8'h40 + 8'(i), 8'h00, 1'b0);
      chk("wq_ready", 32'(req_ready), 32'h1);
    end
    idle(1);
    chk("wq_drained", 32'(busy), 32'h0);

    // Reads behind a held response fill the queue.
    for (int i = 0; i < 5; i++) send(1'b0, 5'(4 + i), 8'h00, 8'h40 + 8'(i), 1'b0);
    chk("rq_full_ready", 32'(req_ready), 32'h0);
    chk("rq_rsp_held", 32'(rsp_valid), 32'h1);
    chk("rq_rsp_first", 32'(rsp_data), 32'h40);
    chk("rq_head_rs1", 32'(Rs1), 32'h5);
    chk("rq_busy", 32'(busy), 32'h1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      chk("rq_blocked", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    send(1'b0, 5'd9, 8'h00, 8'h19, 1'b0);
    idle(10);
    chk("rq_done_busy", 32'(busy), 32'h0);

    // Out-of-range write and reads around the regcount boundary.
    send(1'b1, 5'd12, 8'h77, 8'h00, 1'b0);
    chk("oor_we", 32'(WE), 32'h0);
    chk("oor_rs1", 32'(Rs1), 32'hC);
    chk("oor_err_early", 32'(wr_err), 32'h0);
    idle(1);
    chk("oor_err_pulse", 32'(wr_err), 32'h1);
    tick();
    chk("oor_err_clear", 32'(wr_err), 32'h0);
    send(1'b0, 5'd12, 8'h00, 8'h00, 1'b1);
    send(1'b0, 5'd9, 8'h00, 8'h19, 1'b0);
    send(1'b0, 5'd10, 8'h00, 8'h00, 1'b1);
    idle(4);

    // Reset with three requests queued and a response held.
    rsp_ready = 1'b0;
    send(1'b0, 5'd1, 8'h00, 8'h11, 1'b0);
    send(1'b0, 5'd2, 8'h00, 8'h12, 1'b0);
    send(1'b1, 5'd0, 8'hEE, 8'h00, 1'b0);
    send(1'b1, 5'd1, 8'h55, 8'h00, 1'b0);
    req_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_rsp", 32'(rsp_valid), 32'h1);
    rsp_q.delete();
    wr_q.delete();
    nReset = 1'b0;
    chk("in_rst_we", 32'(WE), 32'h0);
    tick();
    nReset = 1'b1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("post_rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_we", 32'(WE), 32'h0);
    end
    rsp_ready = 1'b1;
    send(1'b0, 5'd0, 8'h00, 8'h10, 1'b0);
    send(1'b0, 5'd1, 8'h00, 8'h11, 1'b0);
    idle(2);

    for (int i = 0; i < 50 && (rsp_q.size() != 0 || wr_q.size() != 0); i++) tick();
    chk("rsp_q_left", 32'(rsp_q.size()), 32'h0);
    chk("wr_q_left", 32'(wr_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
